// File: rtl/iface_force_ctrl_pkg.sv
// Shared command opcodes and channel states for the interface force controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package iface_force_pkg;

  typedef enum logic [1:0] {
    OP_NOP         = 2'd0,
    OP_FORCE       = 2'd1,
    OP_FORCE_TIMED = 2'd2,
    OP_RELEASE     = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    CH_FREE  = 2'd0,
    CH_HELD  = 2'd1,
    CH_TIMED = 2'd2
  } ch_state_e;

endpackage

// File: rtl/iface_force_ctrl_if.sv
// Command handshake bundle between a force-command source and the controller.
// Latency: wires only.
// Backpressure: source holds a command until cmd_valid && cmd_ready at a rising edge.
interface iface_force_ctrl_if
  import iface_force_pkg::*;
#(
  parameter int CH_W  = 1,
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  cmd_op_e          cmd_op;
  logic [CH_W-1:0]  cmd_ch;
  logic [WIDTH-1:0] cmd_value;
  logic [CNT_W-1:0] cmd_cycles;

  modport master (output cmd_valid, cmd_op, cmd_ch, cmd_value, cmd_cycles, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_ch, cmd_value, cmd_cycles, output cmd_ready);
endinterface

// File: rtl/iface_force_chan.sv
// One override channel: sticky or timed force of a value, with release pulse.
// Latency: command takes effect at the accepting edge; pulse one cycle after release/expiry.
// Backpressure: none, accepts a load every cycle.
module iface_force_chan
  import iface_force_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  cmd_op_e          op,
  input  logic [WIDTH-1:0] value,
  input  logic [CNT_W-1:0] cycles,
  output logic [WIDTH-1:0] val,
  output logic             forced,
  output logic             release_pulse
);

  localparam logic [1:0] S_FREE  = CH_FREE;
  localparam logic [1:0] S_HELD  = CH_HELD;
  localparam logic [1:0] S_TIMED = CH_TIMED;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             take;

  // A command only disturbs the channel when it actually changes something;
  // NOP and zero-length timed forces let an active timer keep running.
  always_comb begin
    take = ld && ((op == OP_FORCE) || (op == OP_RELEASE) ||
                  ((op == OP_FORCE_TIMED) && (cycles != '0)));
  end

  // Channel FSM: a new command beats expiry on the same edge; timers stop at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_FREE;
      val           <= '0;
      cnt           <= '0;
      release_pulse <= 1'b0;
    end else begin
      release_pulse <= 1'b0;
      if (take) begin
        case (op)
          OP_FORCE: begin
            state <= S_HELD;
            val   <= value;
            cnt   <= '0;
          end
          OP_FORCE_TIMED: begin
            state <= S_TIMED;
            val   <= value;
            cnt   <= cycles;
          end
          default: begin
            if (state != S_FREE) release_pulse <= 1'b1;
            state <= S_FREE;
            cnt   <= '0;
          end
        endcase
      end else if (state == S_TIMED) begin
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state         <= S_FREE;
          release_pulse <= 1'b1;
        end
      end
    end
  end

  assign forced = (state != S_FREE);

endmodule

// File: rtl/iface_force_ctrl.sv
// Multi-channel override controller: passes or forces per-channel driver values.
// Latency: command visible on drv_out/forced the cycle after acceptance; drv_in passes combinationally.
// Backpressure: cmd_ready low only in and straight out of reset, then one command per cycle.
module iface_force_ctrl
  import iface_force_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 1,
  parameter int CNT_W  = 8,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  iface_force_ctrl_if.slave       cmd,
  input  logic [NUM_CH*WIDTH-1:0] drv_in,
  output logic [NUM_CH*WIDTH-1:0] drv_out,
  output logic [NUM_CH-1:0]       forced,
  output logic [NUM_CH-1:0]       release_pulse,
  output logic                    cmd_err
);

  logic             rdy_q;
  logic             accept;
  logic             ch_ok;
  logic [WIDTH-1:0] ch_val [NUM_CH];

  assign cmd.cmd_ready = rdy_q;
  assign accept        = cmd.cmd_valid && rdy_q;
  // Extra bit so the range check works even when NUM_CH is a power of two.
  assign ch_ok         = ({1'b0, cmd.cmd_ch} < (CH_W + 1)'(NUM_CH));

  // Ready comes up on the first edge out of reset and stays up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  // Flag accepted commands aimed at a channel that does not exist.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmd_err <= 1'b0;
    else        cmd_err <= accept && !ch_ok;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    iface_force_chan #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .ld            (accept && (cmd.cmd_ch == CH_W'(i))),
      .op            (cmd.cmd_op),
      .value         (cmd.cmd_value),
      .cycles        (cmd.cmd_cycles),
      .val           (ch_val[i]),
      .forced        (forced[i]),
      .release_pulse (release_pulse[i])
    );

    assign drv_out[i*WIDTH +: WIDTH] = forced[i] ? ch_val[i] : drv_in[i*WIDTH +: WIDTH];
  end

endmodule

// File: tb/tb_iface_force_ctrl.sv
// Self-checking bench: directed table on a 2x1 instance, model-checked random on a 3x8 instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_iface_force_ctrl;
  import iface_force_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- DUT A: 2 channels x 1 bit ----------------
  iface_force_ctrl_if #(.CH_W(1), .WIDTH(1), .CNT_W(8)) if_a ();
  logic [1:0] drv_a, out_a, frc_a, pls_a;
  logic       err_a;

  iface_force_ctrl #(.NUM_CH(2), .WIDTH(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .cmd(if_a.slave), .drv_in(drv_a), .drv_out(out_a),
    .forced(frc_a), .release_pulse(pls_a), .cmd_err(err_a)
  );

  // ---------------- DUT B: 3 channels x 8 bits ----------------
  iface_force_ctrl_if #(.CH_W(2), .WIDTH(8), .CNT_W(8)) if_b ();
  logic [23:0] drv_b, out_b;
  logic [2:0]  frc_b, pls_b;
  logic        err_b;

  iface_force_ctrl #(.NUM_CH(3), .WIDTH(8), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd(if_b.slave), .drv_in(drv_b), .drv_out(out_b),
    .forced(frc_b), .release_pulse(pls_b), .cmd_err(err_b)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- directed table for DUT A ----------------
  typedef struct {
    logic       vld;
    cmd_op_e    op;
    logic       ch;
    logic       val;
    logic [7:0] cyc;
    logic [1:0] drv;
    logic [1:0] e_out;
    logic [1:0] e_frc;
    logic [1:0] e_pls;
  } vec_t;

  localparam int N_VEC = 27;
  vec_t tbl [N_VEC];

  task automatic drive_a(logic vld, cmd_op_e op, logic ch, logic val, logic [7:0] cyc, logic [1:0] drv);
    if_a.cmd_valid  = vld;
    if_a.cmd_op     = op;
    if_a.cmd_ch     = ch;
    if_a.cmd_value  = val;
    if_a.cmd_cycles = cyc;
    drv_a           = drv;
  endtask

  // ---------------- behavioural model for DUT B ----------------
  // Each channel is either free or forced; a forced channel with rem>0
  // has that many cycles left, rem==0 means held until released.
  logic [7:0] m_val [3];
  bit         m_frc [3];
  int         m_rem [3];
  bit [2:0]   m_pls;
  bit         m_err;

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_val[c] = '0;
      m_frc[c] = 1'b0;
      m_rem[c] = 0;
    end
    m_pls = '0;
    m_err = 1'b0;
  endtask

  task automatic step_b(logic vld, cmd_op_e op, logic [1:0] ch, logic [7:0] val,
                        logic [7:0] cyc, logic [23:0] drv);
    logic [23:0] e_out;
    logic [2:0]  e_frc;
    bit          hit;
    if_b.cmd_valid  = vld;
    if_b.cmd_op     = op;
    if_b.cmd_ch     = ch;
    if_b.cmd_value  = val;
    if_b.cmd_cycles = cyc;
    drv_b           = drv;
    @(posedge clk);
    m_pls = '0;
    m_err = vld && (ch >= 2'd3);
    for (int c = 0; c < 3; c++) begin
      hit = vld && (int'(ch) == c) &&
            ((op == OP_FORCE) || (op == OP_RELEASE) || ((op == OP_FORCE_TIMED) && (cyc != 0)));
      if (hit) begin
        if (op == OP_FORCE) begin
          m_frc[c] = 1'b1; m_val[c] = val; m_rem[c] = 0;
        end else if (op == OP_FORCE_TIMED) begin
          m_frc[c] = 1'b1; m_val[c] = val; m_rem[c] = int'(cyc);
        end else begin
          if (m_frc[c]) m_pls[c] = 1'b1;
          m_frc[c] = 1'b0;
        end
      end else if (m_frc[c] && m_rem[c] > 0) begin
        m_rem[c]--;
        if (m_rem[c] == 0) begin
          m_frc[c] = 1'b0;
          m_pls[c] = 1'b1;
        end
      end
    end
    #1;
    for (int c = 0; c < 3; c++) begin
      e_out[c*8 +: 8] = m_frc[c] ? m_val[c] : drv[c*8 +: 8];
      e_frc[c]        = m_frc[c];
    end
    chk("b_drv_out", 32'(out_b), 32'(e_out));
    chk("b_forced",  32'(frc_b), 32'(e_frc));
    chk("b_pulse",   32'(pls_b), 32'(m_pls));
    chk("b_cmd_err", 32'(err_b), 32'(m_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, OP_FORCE,       1'b0, 1'b0, 8'd0, 2'b11, 2'b10, 2'b01, 2'b00};
    tbl[1]  = '{1'b1, OP_FORCE,       1'b1, 1'b0, 8'd0, 2'b11, 2'b00, 2'b11, 2'b00};
    tbl[2]  = '{1'b1, OP_NOP,         1'b0, 1'b1, 8'd0, 2'b00, 2'b00, 2'b11, 2'b00};
    tbl[3]  = '{1'b0, OP_FORCE,       1'b0, 1'b1, 8'd0, 2'b01, 2'b00, 2'b11, 2'b00};
    tbl[4]  = '{1'b1, OP_RELEASE,     1'b0, 1'b0, 8'd0, 2'b11, 2'b01, 2'b10, 2'b01};
    tbl[5]  = '{1'b0, OP_NOP,         1'b0, 1'b0, 8'd0, 2'b10, 2'b00, 2'b10, 2'b00};
    tbl[6]  = '{1'b1, OP_RELEASE,     1'b1, 1'b0, 8'd0, 2'b10, 2'b10, 2'b00, 2'b10};
    tbl[7]  = '{1'b0, OP_NOP,         1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[8]  = '{1'b1, OP_FORCE_TIMED, 1'b1, 1'b1, 8'd3, 2'b00, 2'b10, 2'b10, 2'b00};
    tbl[9]  = '{1'b0, OP_NOP,         1'b0, 1'b0, 8'd0, 2'b00, 2'b10, 2'b10, 2'b00};
    tbl[10] = '{1'b0, OP_NOP,         1'b0, 1'b0, 8'd0, 2'b00, 2'b10, 2'b10, 2'b00};
    tbl[11] = '{1'b0, OP_NOP,         1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b10};
    tbl[12] = '{1'b0, OP_NOP,         1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[13] = '{1'b1, OP_FORCE_TIMED, 1'b1, 1'b1, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[14] = '{1'b1, OP_FORCE_TIMED, 1'b0, 1'b1, 8'd2, 2'b00, 2'b01, 2'b01, 2'b00};
    tbl[15] = '{1'b0, OP_NOP,         1'b0, 1'b0, 8'd0, 2'b00, 2'b01, 2'b01, 2'b00};
    tbl[16] = '{1'b1, OP_FORCE,       1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 2'b01, 2'b00};
    tbl[17] = '{1'b0, OP_NOP,         1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 2'b01, 2'b00};
    tbl[18] = '{1'b1, OP_RELEASE,     1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b01};
    tbl[19] = '{1'b1, OP_RELEASE,     1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[20] = '{1'b1, OP_RELEASE,     1'b1, 1'b0, 8'd0, 2'b11, 2'b11, 2'b00, 2'b00};
    tbl[21] = '{1'b1, OP_FORCE_TIMED, 1'b0, 1'b0, 8'd1, 2'b11, 2'b10, 2'b01, 2'b00};
    tbl[22] = '{1'b0, OP_NOP,         1'b0, 1'b0, 8'd0, 2'b11, 2'b11, 2'b00, 2'b01};
    tbl[23] = '{1'b1, OP_FORCE_TIMED, 1'b1, 1'b0, 8'd2, 2'b11, 2'b01, 2'b10, 2'b00};
    tbl[24] = '{1'b0, OP_NOP,         1'b0, 1'b0, 8'd0, 2'b11, 2'b01, 2'b10, 2'b00};
    tbl[25] = '{1'b1, OP_RELEASE,     1'b1, 1'b0, 8'd0, 2'b11, 2'b11, 2'b00, 2'b10};
    tbl[26] = '{1'b0, OP_NOP,         1'b0, 1'b0, 8'd0, 2'b11, 2'b11, 2'b00, 2'b00};

    // ---- reset behaviour ----
    rst_n = 1'b0;
    drive_a(1'b0, OP_NOP, 1'b0, 1'b0, 8'd0, 2'b11);
    if_b.cmd_valid = 1'b0; if_b.cmd_op = OP_NOP; if_b.cmd_ch = '0;
    if_b.cmd_value = '0;   if_b.cmd_cycles = '0;  drv_b = 24'h0;
    model_reset();
    #2;
    chk("rst_drv_out", 32'(out_a), 32'h3);
    chk("rst_forced",  32'(frc_a), 32'h0);
    chk("rst_pulse",   32'(pls_a), 32'h0);
    chk("rst_cmd_err", 32'(err_a), 32'h0);
    chk("rst_ready",   32'(if_a.cmd_ready), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ready_held", 32'(if_a.cmd_ready), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 32'(if_a.cmd_ready), 32'h0);
    @(posedge clk); #1;
    chk("ready_after_edge",  32'(if_a.cmd_ready), 32'h1);
    chk("ready_b_after_edge", 32'(if_b.cmd_ready), 32'h1);

    // ---- directed table on DUT A ----
    for (int i = 0; i < N_VEC; i++) begin
      drive_a(tbl[i].vld, tbl[i].op, tbl[i].ch, tbl[i].val, tbl[i].cyc, tbl[i].drv);
      @(posedge clk); #1;
      chk($sformatf("a_out[%0d]", i), 32'(out_a), 32'(tbl[i].e_out));
      chk($sformatf("a_frc[%0d]", i), 32'(frc_a), 32'(tbl[i].e_frc));
      chk($sformatf("a_pls[%0d]", i), 32'(pls_a), 32'(tbl[i].e_pls));
    end
    drive_a(1'b0, OP_NOP, 1'b0, 1'b0, 8'd0, 2'b00);

    // ---- DUT B: out-of-range channel, then a wide force ----
    step_b(1'b1, OP_FORCE, 2'd3, 8'h11, 8'd0, 24'h123456);
    chk("b_bad_ch_err", 32'(err_b), 32'h1);
    chk("b_bad_ch_frc", 32'(frc_b), 32'h0);
    step_b(1'b0, OP_NOP, 2'd0, 8'h00, 8'd0, 24'h123456);
    chk("b_err_drops", 32'(err_b), 32'h0);
    step_b(1'b1, OP_FORCE, 2'd2, 8'hA5, 8'd0, 24'h123456);
    chk("b_force_ch2", 32'(out_b), 32'hA53456);
    step_b(1'b1, OP_RELEASE, 2'd2, 8'h00, 8'd0, 24'h654321);

    // ---- DUT B: random commands against the model ----
    for (int i = 0; i < 400; i++) begin
      cmd_op_e    op;
      logic [1:0] ch;
      logic [7:0] cyc;
      op  = cmd_op_e'($urandom_range(0, 3));
      ch  = 2'($urandom_range(0, 3));
      if (ch == 2'd3 && op == OP_NOP) op = OP_FORCE;
      cyc = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4));
      step_b($urandom_range(0, 9) < 6, op, ch, 8'($urandom), cyc, 24'($urandom));
    end
    if_b.cmd_valid = 1'b0;

    // ---- asynchronous reset during a long timed force ----
    drive_a(1'b1, OP_FORCE_TIMED, 1'b0, 1'b1, 8'd200, 2'b00);
    @(posedge clk); #1;
    drive_a(1'b0, OP_NOP, 1'b0, 1'b0, 8'd0, 2'b10);
    chk("timed200_frc", 32'(frc_a), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    chk("timed200_still", 32'(frc_a), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_frc",     32'(frc_a), 32'h0);
    chk("arst_pulse",   32'(pls_a), 32'h0);
    chk("arst_drv_out", 32'(out_a), 32'h2);
    chk("arst_ready",   32'(if_a.cmd_ready), 32'h0);
    chk("arst_b_frc",   32'(frc_b), 32'h0);
    drive_a(1'b1, OP_FORCE, 1'b1, 1'b0, 8'd0, 2'b10);
    @(posedge clk); #1;
    chk("arst_cmd_drop", 32'(frc_a), 32'h0);
    drive_a(1'b0, OP_NOP, 1'b0, 1'b0, 8'd0, 2'b10);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(if_a.cmd_ready), 32'h1);
    chk("post_rst_frc",   32'(frc_a), 32'h0);
    chk("post_rst_pulse", 32'(pls_a), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
